// File: rtl/calc_sequencer_if.sv
// Operand/opcode bus between the calculator sequencer and the downstream ALU.
interface calc_sequencer_if;
    logic [7:0] num1;
    logic [7:0] num2;
    logic [2:0] selector;
    logic [7:0] alu_y;

    modport master (output num1, output num2, output selector, input alu_y);
    modport slave  (input num1, input num2, input selector, output alu_y);
endinterface

// File: rtl/calc_sequencer.sv
// Button-driven calculator sequencer: debounced enter/clear presses step operands
// and an opcode into an external ALU, then capture and display its result.

module calc_sequencer_debounce #(
    parameter int DEBOUNCE = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          sync1, sync2;
    logic          level, level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_q <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = level & ~level_q;
endmodule

// state  | meaning
// S_A    | await operand A
// S_B    | await operand B
// S_OP   | await operator
// S_EVAL | capture ALU result
// S_SHOW | show result, enter chains it into operand A
module calc_sequencer #(
    parameter int DEBOUNCE = 250000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               switches,
    input  logic [2:0]               op_sel,
    input  logic                     enter_btn,
    input  logic                     clear_btn,
    calc_sequencer_if.master         alu,
    output logic [7:0]               result,
    output logic                     result_valid,
    output logic [7:0]               display_value,
    output logic [2:0]               state
);
    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_B    = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_EVAL = 3'd3;
    localparam logic [2:0] S_SHOW = 3'd4;

    logic       enter_press, clear_press;
    logic [2:0] state_q;
    logic [7:0] num1_q, num2_q, result_q;
    logic [2:0] sel_q;
    logic       valid_q;

    calc_sequencer_debounce #(.DEBOUNCE(DEBOUNCE)) u_enter_db (
        .clk(clk), .reset(reset), .btn(enter_btn), .press(enter_press)
    );
    calc_sequencer_debounce #(.DEBOUNCE(DEBOUNCE)) u_clear_db (
        .clk(clk), .reset(reset), .btn(clear_btn), .press(clear_press)
    );

    always_ff @(posedge clk) begin
        if (reset || clear_press) begin
            state_q  <= S_A;
            num1_q   <= '0;
            num2_q   <= '0;
            sel_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                S_A: if (enter_press) begin
                    num1_q  <= switches;
                    state_q <= S_B;
                end
                S_B: if (enter_press) begin
                    num2_q  <= switches;
                    state_q <= S_OP;
                end
                S_OP: if (enter_press) begin
                    sel_q   <= op_sel;
                    state_q <= S_EVAL;
                end
                // ALU is combinational, so its output is settled one cycle after selector moves
                S_EVAL: begin
                    result_q <= alu.alu_y;
                    valid_q  <= 1'b1;
                    state_q  <= S_SHOW;
                end
                S_SHOW: if (enter_press) begin
                    num1_q  <= result_q;
                    valid_q <= 1'b0;
                    state_q <= S_B;
                end
                default: begin
                    state_q  <= S_A;
                    num1_q   <= '0;
                    num2_q   <= '0;
                    sel_q    <= '0;
                    result_q <= '0;
                    valid_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        display_value = 8'h00;
        case (state_q)
            S_A, S_B:       display_value = switches;
            S_OP:           display_value = num2_q;
            S_EVAL, S_SHOW: display_value = result_q;
            default:        display_value = 8'h00;
        endcase
    end

    assign alu.num1     = num1_q;
    assign alu.num2     = num2_q;
    assign alu.selector = sel_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign state        = state_q;
endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter: DEBOUNCE, 250000, cycles a synchronised button level must hold before it is accepted; legal range 2..2^20.
REQ-002 Port: clk  in  1  single system clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: switches  in  8  operand value from slide switches, sampled on accepted enter press.
REQ-005 Port: op_sel  in  3  operation code, passed unchanged to selector; no decoding in this block.
REQ-006 Port: enter_btn  in  1  raw enter button, asynchronous, active-high, may bounce.
REQ-007 Port: clear_btn  in  1  raw clear button, asynchronous, active-high, may bounce.
REQ-008 Port: alu_y  in  8  result returned from the downstream ALU.
REQ-009 Port: num1  out  8  registered operand A to ALU num1.
REQ-010 Port: num2  out  8  registered operand B to ALU num2.
REQ-011 Port: selector  out  3  registered operation code to ALU selector.
REQ-012 Port: result  out  8  captured ALU result.
REQ-013 Port: result_valid  out  1  high while result holds a completed evaluation.
REQ-014 Port: display_value  out  8  value for the display driver.
REQ-015 Port: state  out  3  current FSM state encoding, for LEDs and debug.

Function
REQ-016 Each button input passes through a 2-flop synchroniser, then a debouncer with its own counter.
- Debouncer output changes only after the synchronised level differs from it for DEBOUNCE consecutive cycles.
- The counter clears on any cycle where the synchronised level equals the debounced level.
REQ-017 A rising edge of the debounced level produces a one-cycle internal press pulse.
- Held buttons produce exactly one pulse.
- Release produces none.
REQ-018 FSM states and encodings:
- S_A=0: await operand A
- S_B=1: await operand B
- S_OP=2: await operator
- S_EVAL=3: capture result
- S_SHOW=4: show result
REQ-019 S_A + enter press: num1<=switches, go S_B.
REQ-020 S_B + enter press: num2<=switches, go S_OP.
REQ-021 S_OP + enter press: selector<=op_sel, go S_EVAL.
REQ-022 S_EVAL: unconditionally on the next edge, result<=alu_y, result_valid<=1, go S_SHOW.
- Result latency is exactly one cycle after selector updates.
- An enter press arriving in S_EVAL is discarded.
REQ-023 S_SHOW + enter press (chaining): num1<=result, result_valid<=0, go S_B.
- num2, selector and result are held.
REQ-024 Clear press in any state:
- num1, num2, result <= 0; selector <= 0; result_valid <= 0; go S_A.
- Clear has priority over a simultaneous enter press.
REQ-025 display_value by state:
- switches in S_A and S_B
- num2 in S_OP
- result in S_EVAL and S_SHOW
REQ-026 All outputs except display_value are registered; display_value is combinational from state and registers.
REQ-027 Arithmetic, overflow and negation belong to the ALU; this block performs no arithmetic on data.
- Values wrap exactly as alu_y delivers them.
REQ-028 Unused state encodings 5-7 return to S_A on the next edge, with the same register effects as a clear.

Reset
REQ-029 While reset is high at a clock edge, the block enters S_A and the following are zero:
- num1, num2, selector, result, result_valid
- synchroniser flops, debounced levels, debounce counters
REQ-030 Reset mid-operation, including S_EVAL, discards any pending press and partial operands.
- A button already held through reset release produces a press only once it is debounced high, i.e. one press after DEBOUNCE+2 cycles.
REQ-031 The first press accepted after reset behaves as in S_A.

Verification
Bench uses DEBOUNCE=4 with the ALU connected; press = button high 10 cycles, low 10 cycles.
REQ-032 Add sequence: switches=0x05 press; 0x03 press; op_sel=3'b001 press -> selector=001, result=0x08, result_valid=1, state=4, display_value=0x08.
REQ-033 Subtract with wrap: A=0x03, B=0x05, op_sel=3'b101 -> result=0xFE; chain press, then B=0x02, op 3'b001 -> num1=0xFE, result=0x00.
REQ-034 Bounce rejection: enter_btn toggles every cycle for 12 cycles, then held high for 10 -> exactly one state advance.
- A 3-cycle glitch alone -> no advance.
REQ-035 Clear priority: enter and clear pressed in the same cycle while in S_OP -> state=0, all outputs 0, num2 not preserved.
REQ-036 Reset in S_EVAL: assert reset for 1 cycle when state=3 -> next cycle state=0, result=0, result_valid=0; no capture of alu_y.
